shared_mem_arbiter: RTL

Parametrised shared-memory block that sits between the core array and the unified instruction/data memory in the top level. It replaces combinational per-core read ports and last-writer-wins multi-port writes with a single-ported, registered memory. A round-robin arbiter grants at most one core access per cycle. Each core gets a request/grant handshake and a registered read-return path, so every core has fair, deterministic access and no writes are silently lost.

---
 rtl/shared_mem_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: single-ported registered memory shared by NUM_CORES
// requesters through a round-robin arbiter. One access commits per cycle;
// reads return one cycle later on the granted core's rdata slice.
module shared_mem_arbiter #(
    parameter int    NUM_CORES = 16,
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 16,
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [NUM_CORES*DATA_W-1:0] rdata,
    output logic [NUM_CORES-1:0]        oob
);

    localparam int          PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] DEPTH_U = 33'(DEPTH);

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    int                search_idx;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              in_range;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    // Round-robin search starting at ptr, wrapping; no grant while in reset.
    always_comb begin
        gnt        = '0;
        grant_idx  = '0;
        grant_any  = 1'b0;
        search_idx = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            search_idx = int'(ptr) + i;
            if (search_idx >= NUM_CORES)
                search_idx = search_idx - NUM_CORES;
            if (rst_n && !grant_any && req[search_idx]) begin
                gnt[search_idx] = 1'b1;
                grant_idx       = PTR_W'(search_idx);
                grant_any       = 1'b1;
            end
        end
    end

    // Steer the granted core's command onto the single memory port.
    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (gnt[i]) begin
                we_sel    = we[i];
                addr_sel  = addr[i*ADDR_W +: ADDR_W];
                wdata_sel = wdata[i*DATA_W +: DATA_W];
            end
        end
        in_range = (33'(addr_sel) < DEPTH_U);
        mem_idx  = addr_sel[IDX_W-1:0];
    end

    // Priority pointer moves just past the core that was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Memory write port; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (grant_any && we_sel && in_range)
            mem[mem_idx] <= wdata_sel;
    end

    // Registered read return plus one-cycle rvalid/oob pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
            oob    <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= gnt & {NUM_CORES{~we_sel}};
            oob    <= gnt & {NUM_CORES{~in_range}};
            for (int i = 0; i < NUM_CORES; i++) begin
                if (gnt[i] && !we_sel)
                    rdata[i*DATA_W +: DATA_W] <= in_range ? mem[mem_idx] : '0;
            end
        end
    end

endmodule
